// File: rtl/wb_trace_pkg.sv
// Shared defaults and trace entry layout for the writeback trace FIFO.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package wb_trace_pkg;

    localparam int TRACE_DEPTH  = 8;
    localparam int TRACE_DATA_W = 32;
    localparam int TRACE_RD_W   = 5;
    localparam int TRACE_TS_W   = 16;

    // One captured writeback, packed as {rd, data, ts} from MSB to LSB
    typedef struct packed {
        logic [TRACE_RD_W-1:0]   rd;
        logic [TRACE_DATA_W-1:0] data;
        logic [TRACE_TS_W-1:0]   ts;
    } trace_entry_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/wb_trace_fifo_core.sv
// Generic synchronous FIFO: storage, wrap-around pointers and occupancy count.
// Latency: a pushed word is visible on dout the cycle after the push.
// Backpressure: push while full is ignored unless a pop happens the same cycle.
module wb_trace_fifo_core #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign count   = cnt;

    // Head is forced to zero when empty so the outputs read clean after reset/clear
    assign dout = empty ? '0 : mem[rd_ptr];

    // Storage write at the tail; flushes and resets cancel the write
    always_ff @(posedge clk) begin
        if (!reset && !clear && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy update; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/wb_trace_fifo.sv
// Captures CPU writebacks with a cycle timestamp into a FIFO for trace readout.
// Latency: a captured writeback appears on out_* one cycle after capture, no bypass.
// Backpressure: out_valid/out_ready; captures into a full FIFO without a pop are dropped and counted.
module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DEPTH   = TRACE_DEPTH,
    parameter int DATA_W  = TRACE_DATA_W,
    parameter int RD_W    = TRACE_RD_W,
    parameter int TS_W    = TRACE_TS_W,
    parameter int SKIP_X0 = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   wb_we,
    input  logic [RD_W-1:0]        wb_rd,
    input  logic [DATA_W-1:0]      wb_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RD_W-1:0]        out_rd,
    output logic [DATA_W-1:0]      out_data,
    output logic [TS_W-1:0]        out_ts,
    output logic [$clog2(DEPTH):0] count,
    output logic [7:0]             drop_cnt,
    output logic                   overflow
);

    localparam int E_W = RD_W + DATA_W + TS_W;

    logic [TS_W-1:0] ts;
    logic            capture;
    logic            pop;
    logic            full;
    logic            empty;
    logic            drop;
    logic [E_W-1:0]  head;

    // Register 0 writes are architecturally void, so optionally filter them out
    assign capture = wb_we && !((SKIP_X0 != 0) && (wb_rd == '0));
    assign pop     = out_ready & out_valid;
    assign drop    = capture & full & ~pop;

    assign out_valid = ~empty;
    assign {out_rd, out_data, out_ts} = head;

    wb_trace_fifo_core #(
        .DEPTH (DEPTH),
        .W     (E_W)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (capture),
        .pop   (out_ready),
        .din   ({wb_rd, wb_result, ts}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Free-running timestamp; clear leaves it running, only reset restarts it
    always_ff @(posedge clk) begin
        if (reset) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    // Lost-capture accounting: saturating counter plus sticky flag
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            drop_cnt <= sat_inc8(drop_cnt);
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_trace_fifo.sv
module tb_wb_trace_fifo;
    import wb_trace_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic [15:0] out_ts;
    logic [3:0]  count;
    logic [7:0]  drop_cnt;
    logic        overflow;

    always #5 clk = ~clk;

    wb_trace_fifo #(
        .DEPTH   (8),
        .DATA_W  (32),
        .RD_W    (5),
        .TS_W    (16),
        .SKIP_X0 (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_result (wb_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rd    (out_rd),
        .out_data  (out_data),
        .out_ts    (out_ts),
        .count     (count),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    trace_entry_t sb[$];
    logic [15:0]  m_ts;
    int           m_drop;
    logic         m_ovf;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        rdy;
        logic        exp_valid;
        logic [3:0]  exp_cnt;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic [15:0] exp_ts;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model
    task automatic tick(input logic we, input logic [4:0] rd, input logic [31:0] res,
                        input logic rdy, input logic clr, input logic rst);
        trace_entry_t e;
        logic         pop;
        wb_we     = we;
        wb_rd     = rd;
        wb_result = res;
        out_ready = rdy;
        clear     = clr;
        reset     = rst;
        #2;
        chk("valid", 64'(out_valid), 64'(sb.size() != 0));
        chk("count", 64'(count), 64'(sb.size()));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (rst) begin
            sb.delete();
            m_drop = 0;
            m_ovf  = 1'b0;
            m_ts   = 16'd0;
        end else if (clr) begin
            sb.delete();
            m_drop = 0;
            m_ovf  = 1'b0;
            m_ts++;
        end else begin
            pop = rdy && (sb.size() != 0);
            if (pop) begin
                e = sb.pop_front();
                chk("sb_rd", 64'(out_rd), 64'(e.rd));
                chk("sb_data", 64'(out_data), 64'(e.data));
                chk("sb_ts", 64'(out_ts), 64'(e.ts));
            end
            if (we && rd != 5'd0) begin
                if (sb.size() < DEPTH) begin
                    e.rd   = rd;
                    e.data = res;
                    e.ts   = m_ts;
                    sb.push_back(e);
                end else begin
                    if (m_drop < 255) m_drop++;
                    m_ovf = 1'b1;
                end
            end
            m_ts++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_result = 32'd0; out_ready = 1'b0;
        m_ts = 16'd0; m_drop = 0; m_ovf = 1'b0;

        for (int k = 0; k < 5; k++)
            vt[k] = '{1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0, 5'd0, 32'd0, 16'd0};
        vt[5]  = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 1'b1, 4'd1, 5'd3,  32'hDEADBEEF, 16'd5};
        vt[6]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 1'b1, 4'd1, 5'd3,  32'hDEADBEEF, 16'd5};
        vt[7]  = '{1'b0, 5'd7,  32'h00005555, 1'b0, 1'b1, 4'd1, 5'd3,  32'hDEADBEEF, 16'd5};
        vt[8]  = '{1'b0, 5'd0,  32'h00000000, 1'b1, 1'b0, 4'd0, 5'd0,  32'h00000000, 16'd0};
        vt[9]  = '{1'b1, 5'd7,  32'h11111111, 1'b1, 1'b1, 4'd1, 5'd7,  32'h11111111, 16'd9};
        vt[10] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 1'b1, 4'd1, 5'd31, 32'hA5A5A5A5, 16'd10};
        vt[11] = '{1'b0, 5'd0,  32'h00000000, 1'b1, 1'b0, 4'd0, 5'd0,  32'h00000000, 16'd0};

        #1;
        repeat (3) tick(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rd", 64'(out_rd), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_ts", 64'(out_ts), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // Table: first capture at ts 5, x0 filter, we=0, hold, pop, push+pop at count 1
        for (int k = 0; k < 12; k++) begin
            tick(vt[k].we, vt[k].rd, vt[k].res, vt[k].rdy, 1'b0, 1'b0);
            chk($sformatf("row%0d_valid", k), 64'(out_valid), 64'(vt[k].exp_valid));
            chk($sformatf("row%0d_count", k), 64'(count), 64'(vt[k].exp_cnt));
            if (vt[k].exp_valid) begin
                chk($sformatf("row%0d_rd", k), 64'(out_rd), 64'(vt[k].exp_rd));
                chk($sformatf("row%0d_data", k), 64'(out_data), 64'(vt[k].exp_data));
                chk($sformatf("row%0d_ts", k), 64'(out_ts), 64'(vt[k].exp_ts));
            end
        end

        // Ten captures into an 8-deep FIFO with no consumer
        for (int i = 1; i <= 10; i++) tick(1'b1, 5'(i), 32'($urandom), 1'b0, 1'b0, 1'b0);
        chk("fill_count", 64'(count), 64'd8);
        chk("fill_drop", 64'(drop_cnt), 64'd2);
        chk("fill_ovf", 64'(overflow), 64'd1);
        chk("fill_head", 64'(out_rd), 64'd1);

        // Capture while full with a same-cycle pop: accepted, no drop
        tick(1'b1, 5'd20, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
        chk("fullpp_count", 64'(count), 64'd8);
        chk("fullpp_drop", 64'(drop_cnt), 64'd2);
        chk("fullpp_head", 64'(out_rd), 64'd2);
        repeat (7) tick(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("last_rd", 64'(out_rd), 64'd20);
        chk("last_data", 64'(out_data), 64'hCAFEF00D);
        tick(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("drained", 64'(count), 64'd0);

        // Drop counter saturation, then clear with a competing capture
        tick(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 308; i++) tick(1'b1, 5'(i % 31 + 1), 32'(i), 1'b0, 1'b0, 1'b0);
        chk("sat_drop", 64'(drop_cnt), 64'd255);
        chk("sat_ovf", 64'(overflow), 64'd1);
        chk("sat_count", 64'(count), 64'd8);
        tick(1'b1, 5'd9, 32'd0, 1'b1, 1'b1, 1'b0);
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_drop", 64'(drop_cnt), 64'd0);
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_valid", 64'(out_valid), 64'd0);

        // Reset mid-drain with five entries held
        for (int i = 0; i < 6; i++) tick(1'b1, 5'(i + 1), 32'($urandom), 1'b0, 1'b0, 1'b0);
        tick(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("middrain_count", 64'(count), 64'd5);
        tick(1'b1, 5'd4, 32'h77, 1'b1, 1'b0, 1'b1);
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_count", 64'(count), 64'd0);
        chk("mrst_rd", 64'(out_rd), 64'd0);
        chk("mrst_data", 64'(out_data), 64'd0);
        chk("mrst_ts", 64'(out_ts), 64'd0);
        chk("mrst_drop", 64'(drop_cnt), 64'd0);
        chk("mrst_ovf", 64'(overflow), 64'd0);

        // First cycle after reset captures with timestamp 0
        tick(1'b1, 5'd6, 32'h600D, 1'b0, 1'b0, 1'b0);
        chk("post_rst_ts", 64'(out_ts), 64'd0);
        chk("post_rst_rd", 64'(out_rd), 64'd6);
        tick(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Timestamp wrap from 0xFFFF to 0
        repeat (65533) tick(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 5'd8, 32'd1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 5'd9, 32'd2, 1'b0, 1'b0, 1'b0);
        chk("wrap_count", 64'(count), 64'd2);
        chk("wrap_ts_hi", 64'(out_ts), 64'hFFFF);
        tick(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("wrap_ts_lo", 64'(out_ts), 64'd0);
        chk("wrap_rd", 64'(out_rd), 64'd9);
        tick(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_trace_fifo.md
WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter DATA_W, default 32, writeback result width.
REQ-003 SHALL have parameter RD_W, default 5, destination register index width.
REQ-004 SHALL have parameter TS_W, default 16, cycle timestamp width.
REQ-005 SHALL have parameter SKIP_X0, default 1, when 1 writes to register 0 are not captured.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port clear  input  1  synchronous flush of FIFO, counters and sticky flag.
REQ-009 SHALL have port wb_we  input  1  CPU writeback write-enable.
REQ-010 SHALL have port wb_rd  input  RD_W  CPU writeback destination register.
REQ-011 SHALL have port wb_result  input  DATA_W  CPU writeback data.
REQ-012 SHALL have port out_valid  output  1  head entry available.
REQ-013 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-014 SHALL have port out_rd / out_data / out_ts  output  RD_W / DATA_W / TS_W  head entry fields.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 SHALL have port drop_cnt  output  8  saturating count of lost captures.
REQ-017 SHALL have port overflow  output  1  sticky, set on first dropped capture.

Function
REQ-018 SHALL keep a free-running TS_W-bit cycle counter, incrementing every cycle, wrapping from all-ones to 0.
REQ-019 SHALL form a capture request in a cycle where wb_we=1 and not (SKIP_X0=1 and wb_rd=0).
REQ-020 SHALL store {wb_rd, wb_result, timestamp-of-that-cycle} at tail on capture when not full or when a pop occurs the same cycle.
REQ-021 SHALL drop the capture when full and no pop in that cycle: increment drop_cnt (saturate at 255), set overflow.
REQ-022 SHALL pop the head when out_valid=1 and out_ready=1; out_ready with out_valid=0 has no effect.
REQ-023 SHALL present a captured entry on out_* with out_valid=1 the cycle after capture (latency 1); no bypass.
REQ-024 SHALL hold out_* and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL preserve capture order; pointers wrap modulo DEPTH.
REQ-026 SHALL update count by +1 on push only, -1 on pop only, unchanged on push+pop or neither.
REQ-027 SHALL, on simultaneous push and pop at DEPTH, accept the push with no drop; at empty, pop is not possible so push alone occurs.
REQ-028 SHALL, on clear, empty the FIFO, zero drop_cnt and overflow, and ignore any same-cycle capture; timestamp counter continues.
REQ-029 SHALL never assert out_valid with count=0, and count SHALL never exceed DEPTH.

Reset
REQ-030 SHALL, while reset=1, set out_valid=0, count=0, drop_cnt=0, overflow=0, timestamp=0, pointers=0; out_rd/out_data/out_ts=0.
REQ-031 SHALL give reset priority over clear, capture and pop; a capture in a reset cycle is discarded, not counted as dropped.
REQ-032 SHALL begin capturing in the first cycle after reset deasserts; that cycle has timestamp 0.

Structure
REQ-033 SHALL place default widths and the trace entry struct {rd, data, ts} in shared package wb_trace_pkg.
REQ-034 SHALL implement storage and pointers in one sub-module wb_trace_fifo_core (generic sync FIFO, push/pop/full/empty/count); capture filter, timestamp and drop accounting live in wb_trace_fifo.
REQ-035 SHALL be synthesizable, no latches, no combinational path from wb_* inputs to out_*.

Verification
REQ-036 SHALL test: reset released, wb_we=1 rd=3 result=0xDEADBEEF at ts 5 -> next cycle out_valid=1, out_rd=3, out_data=0xDEADBEEF, out_ts=5, count=1.
REQ-037 SHALL test: SKIP_X0=1, wb_we=1 rd=0 -> no capture, count=0; wb_we=0 rd=7 -> no capture.
REQ-038 SHALL test: out_ready=0, 10 consecutive captures (DEPTH=8) -> count=8, drop_cnt=2, overflow=1; drain yields first 8 in order.
REQ-039 SHALL test: full FIFO, capture with out_ready=1 same cycle -> count stays 8, drop_cnt unchanged, new entry appears last.
REQ-040 SHALL test: 300 drops -> drop_cnt=255; then clear=1 -> count=0, drop_cnt=0, overflow=0, out_valid=0 next cycle.
REQ-041 SHALL test: reset asserted mid-drain with count=5 -> next cycle all outputs at reset values; timestamp counter restarts at 0, wrapping 0xFFFF->0 after 65536 cycles.
